// File: rtl/tl_arb_pkg.sv
// tl_arb_pkg: shared types and bus widths for the two-master TileLink-UL arbiter
package tl_arb_pkg;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MW = DW / 8;
    localparam int SW = 4;
    localparam int KW = 1;
    localparam int ZW = 3;
    localparam logic GRANT_M0 = 1'b0;
    localparam logic GRANT_M1 = 1'b1;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/tilelink.sv
// tilelink: TileLink-UL A/D channel bundle
interface tilelink;
    import tl_arb_pkg::*;
    logic          a_valid;
    logic          a_ready;
    logic [2:0]    a_opcode;
    logic [2:0]    a_param;
    logic [ZW-1:0] a_size;
    logic [SW-1:0] a_source;
    logic [AW-1:0] a_address;
    logic [MW-1:0] a_mask;
    logic [DW-1:0] a_data;
    logic          a_corrupt;
    logic          d_valid;
    logic          d_ready;
    logic [2:0]    d_opcode;
    logic [1:0]    d_param;
    logic [ZW-1:0] d_size;
    logic [SW-1:0] d_source;
    logic [KW-1:0] d_sink;
    logic          d_denied;
    logic [DW-1:0] d_data;
    logic          d_corrupt;
    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, d_ready,
        input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt
    );
    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, d_ready,
        output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt
    );
endinterface

// File: rtl/tl_arbiter2_rr_pick.sv
// rr_pick: two-input picker; ties go to the master not served last, or to m0 when rr_en=0
module rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr_en,
    output logic       gnt
);
    always_comb gnt = &req ? (rr_en & ~last) : req[1];
endmodule

// File: rtl/tl_arbiter2.sv
// tl_arbiter2: merges two TileLink-UL masters onto one bus, one transaction in flight,
// grant locked from A arbitration until the matching D handshake
module tl_arbiter2
    import tl_arb_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic    clk,
    input  logic    rst_n,
    tilelink.slave  m0,
    tilelink.slave  m1,
    tilelink.master out,
    output logic    grant_o,
    output logic    busy_o
);
    state_t state;
    logic   last_grant;
    logic   pick;
    logic   in_req;
    logic   in_resp;

    rr_pick u_pick (
        .req   ({m1.a_valid, m0.a_valid}),
        .last  (last_grant),
        .rr_en (ROUND_ROBIN),
        .gnt   (pick)
    );

    assign in_req  = state == S_REQ;
    assign in_resp = state == S_RESP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= GRANT_M1;
            grant_o    <= GRANT_M0;
            busy_o     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (m0.a_valid | m1.a_valid) begin
                    grant_o <= pick;
                    busy_o  <= 1'b1;
                    state   <= S_REQ;
                end
                S_REQ: if (out.a_valid & out.a_ready) state <= S_RESP;
                S_RESP: if (out.d_valid & out.d_ready) begin
                    last_grant <= grant_o;
                    busy_o     <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // D is only routed in S_RESP, so a D beat during S_REQ is never acknowledged
    always_comb begin
        out.a_valid = in_req & (grant_o ? m1.a_valid : m0.a_valid);
        {out.a_opcode, out.a_param, out.a_size, out.a_source, out.a_address, out.a_mask, out.a_data, out.a_corrupt} =
            grant_o ? {m1.a_opcode, m1.a_param, m1.a_size, m1.a_source, m1.a_address, m1.a_mask, m1.a_data, m1.a_corrupt}
                    : {m0.a_opcode, m0.a_param, m0.a_size, m0.a_source, m0.a_address, m0.a_mask, m0.a_data, m0.a_corrupt};
        m0.a_ready  = in_req & ~grant_o & out.a_ready;
        m1.a_ready  = in_req & grant_o & out.a_ready;
        out.d_ready = in_resp & (grant_o ? m1.d_ready : m0.d_ready);
        {m0.d_valid, m0.d_opcode, m0.d_param, m0.d_size, m0.d_source, m0.d_sink, m0.d_denied, m0.d_data, m0.d_corrupt} =
            (in_resp & ~grant_o) ? {out.d_valid, out.d_opcode, out.d_param, out.d_size, out.d_source, out.d_sink, out.d_denied, out.d_data, out.d_corrupt} : '0;
        {m1.d_valid, m1.d_opcode, m1.d_param, m1.d_size, m1.d_source, m1.d_sink, m1.d_denied, m1.d_data, m1.d_corrupt} =
            (in_resp & grant_o) ? {out.d_valid, out.d_opcode, out.d_param, out.d_size, out.d_source, out.d_sink, out.d_denied, out.d_data, out.d_corrupt} : '0;
    end
endmodule

// File: tb/tb_tl_arbiter2.sv
// tb_tl_arbiter2: directed scoreboard bench for tl_arbiter2 (round-robin and fixed-priority instances)
module tb_tl_arbiter2;
    import tl_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tilelink i0 (), i1 (), io (), f0 (), f1 (), fo ();
    logic grant_o, busy_o, grant_fp, busy_fp;

    tl_arbiter2 #(.ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .m0(i0), .m1(i1), .out(io), .grant_o(grant_o), .busy_o(busy_o)
    );
    tl_arbiter2 #(.ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .m0(f0), .m1(f1), .out(fo), .grant_o(grant_fp), .busy_o(busy_fp)
    );

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_a[$];
    logic [64:0] exp_d[$];
    logic [32:0] ea;
    logic [64:0] ed;
    bit fp_seq[$];
    int lat = 1;
    int stall = 0;
    int d_cnt = 0;
    bit a_hs, d_hs, a_vis, d_pend, fa_hs, fd_hs;
    logic [31:0] cap_addr;
    logic [3:0] cap_src, fcap;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rsp_data(input logic [31:0] a);
        return a == 32'h8000_0000 ? 64'h1122334455667788 : {~a, a};
    endfunction

    task automatic got_d(input bit m, input logic [63:0] data, input logic [3:0] src);
        if (exp_d.size() == 0) chk("d_extra", 1, 0);
        else begin
            ed = exp_d.pop_front();
            chk("d_beat", {m, data, src}, {ed, 3'b0, ed[64]});
        end
    endtask

    // monitor: samples mid-cycle the values the next posedge will see
    initial forever begin
        @(negedge clk);
        a_hs  = io.a_valid & io.a_ready;
        d_hs  = io.d_valid & io.d_ready;
        a_vis = io.a_valid;
        fa_hs = fo.a_valid & fo.a_ready;
        fd_hs = fo.d_valid & fo.d_ready;
        if (fa_hs) begin
            fp_seq.push_back(grant_fp);
            fcap = fo.a_source;
        end
        if (a_hs) begin
            cap_addr = io.a_address;
            cap_src  = io.a_source;
            if (exp_a.size() == 0) chk("a_extra", 1, 0);
            else begin
                ea = exp_a.pop_front();
                chk("a_beat", {grant_o, io.a_address, io.a_source}, {ea, 3'b0, ea[32]});
            end
        end
        if (io.d_valid) chk("d_isolate", grant_o ? i0.d_valid : i1.d_valid, 0);
        if (i0.d_valid & i0.d_ready) got_d(1'b0, i0.d_data, i0.d_source);
        if (i1.d_valid & i1.d_ready) got_d(1'b1, i1.d_data, i1.d_source);
    end

    // slave model for the round-robin instance
    initial begin
        io.a_ready = 0; io.d_valid = 0; io.d_opcode = 3'd1; io.d_param = 0; io.d_size = 3'd3;
        io.d_source = 0; io.d_sink = 0; io.d_denied = 0; io.d_data = 0; io.d_corrupt = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                d_pend = 0; io.d_valid = 0; io.a_ready = 0;
            end else begin
                if (d_hs) begin io.d_valid = 0; d_pend = 0; end
                if (a_hs) begin d_pend = 1; d_cnt = lat; end
                if (d_pend && !io.d_valid) begin
                    if (d_cnt == 0) begin
                        io.d_valid = 1; io.d_data = rsp_data(cap_addr); io.d_source = cap_src;
                    end else d_cnt--;
                end
                if (a_vis && !a_hs && stall > 0) stall--;
                io.a_ready = !d_pend && stall == 0;
            end
        end
    end

    // always-ready slave for the fixed-priority instance
    initial begin
        fo.a_ready = 1; fo.d_valid = 0; fo.d_opcode = 3'd1; fo.d_param = 0; fo.d_size = 3'd3;
        fo.d_source = 0; fo.d_sink = 0; fo.d_denied = 0; fo.d_data = 0; fo.d_corrupt = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) fo.d_valid = 0;
            else begin
                if (fd_hs) fo.d_valid = 0;
                if (fa_hs) begin fo.d_valid = 1; fo.d_data = 64'hfeed; fo.d_source = fcap; end
            end
        end
    end

    task automatic req(input bit m, input logic [31:0] addr);
        if (m) begin i1.a_valid = 1; i1.a_address = addr; i1.a_source = 4'd1; end
        else begin i0.a_valid = 1; i0.a_address = addr; i0.a_source = 4'd0; end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (m ? (i1.a_valid & i1.a_ready) : (i0.a_valid & i0.a_ready)) begin
                @(posedge clk); #1;
                if (m) i1.a_valid = 0; else i0.a_valid = 0;
                return;
            end
        end
        chk("req_timeout", 1, 0);
        if (m) i1.a_valid = 0; else i0.a_valid = 0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy_o) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_fa(input bit m);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (m ? (f1.a_valid & f1.a_ready) : (f0.a_valid & f0.a_ready)) return;
        end
        chk("fp_timeout", 1, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic init_master(input bit fp);
        if (fp) begin
            f0.a_valid = 0; f0.a_opcode = 3'd4; f0.a_param = 0; f0.a_size = 3'd3; f0.a_source = 4'd0;
            f0.a_address = 32'h100; f0.a_mask = 8'hff; f0.a_data = 0; f0.a_corrupt = 0; f0.d_ready = 1;
            f1.a_valid = 0; f1.a_opcode = 3'd4; f1.a_param = 0; f1.a_size = 3'd3; f1.a_source = 4'd1;
            f1.a_address = 32'h200; f1.a_mask = 8'hff; f1.a_data = 0; f1.a_corrupt = 0; f1.d_ready = 1;
        end else begin
            i0.a_valid = 0; i0.a_opcode = 3'd4; i0.a_param = 0; i0.a_size = 3'd3; i0.a_source = 4'd0;
            i0.a_address = 0; i0.a_mask = 8'hff; i0.a_data = 0; i0.a_corrupt = 0; i0.d_ready = 1;
            i1.a_valid = 0; i1.a_opcode = 3'd4; i1.a_param = 0; i1.a_size = 3'd3; i1.a_source = 4'd1;
            i1.a_address = 0; i1.a_mask = 8'hff; i1.a_data = 0; i1.a_corrupt = 0; i1.d_ready = 1;
        end
    endtask

    initial begin
        bit found;
        bit [4:0] fp_exp;
        init_master(1'b0);
        init_master(1'b1);
        @(negedge clk);
        chk("rst_out_a_valid", io.a_valid, 0);
        chk("rst_out_d_ready", io.d_ready, 0);
        chk("rst_a_ready", {i0.a_ready, i1.a_ready}, 0);
        chk("rst_d_valid", {i0.d_valid, i1.d_valid}, 0);
        chk("rst_d_data", {i0.d_data, i1.d_data}, 0);
        chk("rst_busy_grant", {busy_o, grant_o}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // single m0 Get, one-cycle arbitration latency
        @(posedge clk); #1;
        exp_a.push_back({1'b0, 32'h8000_0000});
        exp_d.push_back({1'b0, 64'h1122334455667788});
        fork
            req(1'b0, 32'h8000_0000);
            begin
                @(negedge clk);
                chk("t1_lat_idle", {busy_o, io.a_valid}, 0);
                @(negedge clk);
                chk("t1_out_a", {io.a_valid, io.a_address}, {1'b1, 32'h8000_0000});
            end
        join
        wait_idle();

        // simultaneous pairs after reset: m0, m1, m0, m1
        do_reset();
        for (int p = 0; p < 2; p++) begin
            @(posedge clk); #1;
            exp_a.push_back({1'b0, 32'h1000 + 32'(p)});
            exp_a.push_back({1'b1, 32'h2000 + 32'(p)});
            exp_d.push_back({1'b0, rsp_data(32'h1000 + 32'(p))});
            exp_d.push_back({1'b1, rsp_data(32'h2000 + 32'(p))});
            fork
                req(1'b0, 32'h1000 + 32'(p));
                req(1'b1, 32'h2000 + 32'(p));
            join
            wait_idle();
        end

        // slave stalls a_ready for 5 cycles
        stall = 5;
        @(posedge clk); #1;
        exp_a.push_back({1'b1, 32'h3000});
        exp_d.push_back({1'b1, rsp_data(32'h3000)});
        fork
            req(1'b1, 32'h3000);
            begin
                @(negedge clk);
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    chk("t4_hold", {io.a_valid, io.a_address, io.a_source}, {1'b1, 32'h3000, 4'd1});
                    chk("t4_other_ready", i0.a_ready, 0);
                    chk("t4_no_d_ready", io.d_ready, 0);
                    chk("t4_a_ready", io.a_ready, k == 5);
                end
            end
        join
        wait_idle();

        // granted master back-pressures D for 3 cycles
        i0.d_ready = 0;
        @(posedge clk); #1;
        exp_a.push_back({1'b0, 32'h4000});
        exp_d.push_back({1'b0, rsp_data(32'h4000)});
        req(1'b0, 32'h4000);
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            found = io.d_valid;
        end
        chk("t5_d_arrives", found, 1);
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clk);
            chk("t5_stall", {io.d_ready, busy_o, i0.d_valid}, 3'b011);
        end
        @(posedge clk); #1;
        i0.d_ready = 1;
        @(negedge clk);
        chk("t5_release", io.d_ready, 1);
        wait_idle();

        // reset asserted while waiting in S_RESP
        lat = 5;
        @(posedge clk); #1;
        exp_a.push_back({1'b0, 32'h5000});
        req(1'b0, 32'h5000);
        @(negedge clk);
        chk("t6_in_resp", {busy_o, io.d_ready}, 2'b11);
        #2 rst_n = 0;
        #1;
        chk("t6_abort_busy", {busy_o, grant_o}, 0);
        chk("t6_abort_valids", {io.a_valid, io.d_ready, i0.d_valid, i0.a_ready, i1.d_valid}, 0);
        lat = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        exp_a.push_back({1'b1, 32'h6000});
        exp_d.push_back({1'b1, rsp_data(32'h6000)});
        req(1'b1, 32'h6000);
        wait_idle();

        // fixed priority: m1 only gets gaps where m0 is idle
        @(posedge clk); #1;
        f0.a_valid = 1;
        f1.a_valid = 1;
        repeat (3) wait_fa(1'b0);
        @(posedge clk); #1;
        f0.a_valid = 0;
        wait_fa(1'b1);
        @(posedge clk); #1;
        f0.a_valid = 1;
        wait_fa(1'b0);
        @(posedge clk); #1;
        f0.a_valid = 0;
        f1.a_valid = 0;
        repeat (4) @(negedge clk);
        fp_exp = 5'b01000;
        chk("t3_count", fp_seq.size(), 5);
        for (int k = 0; k < 5 && k < fp_seq.size(); k++) chk("t3_seq", fp_seq[k], fp_exp[k]);
        chk("t3_idle", busy_fp, 0);

        chk("sb_a_empty", exp_a.size(), 0);
        chk("sb_d_empty", exp_d.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
